// File: rtl/medikit_pkg.sv
// medikit_pkg
//   Shared definitions for the medicine-kit digit bus: 7-segment digit codes
//   (abcdefg, MSB = a), keypad key codes, the keypad debounce state type and
//   small conversion helpers. The display and controller blocks use it too.
package medikit_pkg;

   localparam logic [6:0] SEG_0 = 7'b1111110;
   localparam logic [6:0] SEG_1 = 7'b0110000;
   localparam logic [6:0] SEG_2 = 7'b1101101;
   localparam logic [6:0] SEG_3 = 7'b1111001;
   localparam logic [6:0] SEG_4 = 7'b0110011;
   localparam logic [6:0] SEG_5 = 7'b1011011;
   localparam logic [6:0] SEG_6 = 7'b1011111;
   localparam logic [6:0] SEG_7 = 7'b1110000;
   localparam logic [6:0] SEG_8 = 7'b1111111;
   localparam logic [6:0] SEG_9 = 7'b1111011;

   // Key code = row*4 + col on the 4x4 matrix.
   localparam logic [3:0] KEY_STAR = 4'd12;
   localparam logic [3:0] KEY_ZERO = 4'd13;
   localparam logic [3:0] KEY_HASH = 4'd14;

   typedef enum logic [1:0] {
      KP_IDLE,
      KP_PRESSING,
      KP_HELD,
      KP_RELEASING
   } kp_state_t;

   // Digits are only ever 0..9; anything else falls back to the 0 pattern so
   // the all-dark code 0000000 can never reach the bus.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      case (d)
         4'd0:    bcd_to_seg = SEG_0;
         4'd1:    bcd_to_seg = SEG_1;
         4'd2:    bcd_to_seg = SEG_2;
         4'd3:    bcd_to_seg = SEG_3;
         4'd4:    bcd_to_seg = SEG_4;
         4'd5:    bcd_to_seg = SEG_5;
         4'd6:    bcd_to_seg = SEG_6;
         4'd7:    bcd_to_seg = SEG_7;
         4'd8:    bcd_to_seg = SEG_8;
         4'd9:    bcd_to_seg = SEG_9;
         default: bcd_to_seg = SEG_0;
      endcase
   endfunction

   function automatic logic key_is_digit(input logic [3:0] code);
      case (code)
         4'd3, 4'd7, 4'd11, 4'd15, KEY_STAR, KEY_HASH: key_is_digit = 1'b0;
         default:                                      key_is_digit = 1'b1;
      endcase
   endfunction

   // Numeric value of a digit key; only meaningful when key_is_digit().
   function automatic logic [3:0] key_to_digit(input logic [3:0] code);
      case (code)
         4'd0:     key_to_digit = 4'd1;
         4'd1:     key_to_digit = 4'd2;
         4'd2:     key_to_digit = 4'd3;
         4'd4:     key_to_digit = 4'd4;
         4'd5:     key_to_digit = 4'd5;
         4'd6:     key_to_digit = 4'd6;
         4'd8:     key_to_digit = 4'd7;
         4'd9:     key_to_digit = 4'd8;
         4'd10:    key_to_digit = 4'd9;
         KEY_ZERO: key_to_digit = 4'd0;
         default:  key_to_digit = 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/keypad_scan.sv
// keypad_scan
//   Drives the 4x4 matrix columns one at a time, assembles one scan frame per
//   column rotation and debounces the frame results.
//   Ports:
//     clkin, rst        clock, synchronous active-high reset
//     row_n[3:0]        matrix rows, active low
//     col_n[3:0]        column drive, one bit low at a time
//     accept            combinational strobe on the edge a press is accepted
//     accept_code[3:0]  code of the key being accepted (valid with accept)
//     key_valid         registered one-cycle pulse, cycle after accept
//     key_code[3:0]     last accepted key, held between pulses
module keypad_scan
   import medikit_pkg::*;
#(
   parameter int SCAN_CYCLES = 250,
   parameter int DEBOUNCE    = 4
) (
   input  logic       clkin,
   input  logic       rst,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic       accept,
   output logic [3:0] accept_code,
   output logic       key_valid,
   output logic [3:0] key_code
);

   localparam int SW = $clog2(SCAN_CYCLES);
   localparam int FW = $clog2(DEBOUNCE + 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
   localparam logic [FW-1:0] DEB_LAST  = FW'(DEBOUNCE - 1);

   logic [SW-1:0] scan_cnt;
   logic [1:0]    col_idx;
   logic          slot_end;
   logic          frame_end;

   // Frame accumulator: number of low (row, col) points seen so far,
   // saturating at 2 (= "more than one"), and the code of the single hit.
   logic [1:0]    acc_hits;
   logic [3:0]    acc_code;
   logic [2:0]    slot_hits;
   logic [1:0]    slot_row;
   logic [2:0]    hit_sum;
   logic [1:0]    merged_hits;
   logic [3:0]    merged_code;
   logic          frame_key;

   kp_state_t     state, state_nxt;
   logic [FW-1:0] deb_cnt, deb_cnt_nxt;
   logic [3:0]    cand, cand_nxt;

   assign col_n     = ~(4'b0001 << col_idx);
   assign slot_end  = (scan_cnt == SCAN_LAST);
   assign frame_end = slot_end && (col_idx == 2'd3);

   // NOTE: every variable written in always_comb gets a default at the top;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      slot_hits = '0;
      slot_row  = '0;
      for (int r = 0; r < 4; r++) begin
         if (!row_n[r]) begin
            slot_hits = slot_hits + 3'd1;
            slot_row  = 2'(r);
         end
      end
      hit_sum     = {1'b0, acc_hits} + slot_hits;
      merged_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
      merged_code = (slot_hits == 3'd1) ? {slot_row, col_idx} : acc_code;
      frame_key   = (merged_hits == 2'd1);
   end

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clkin) begin
      if (rst) begin
         scan_cnt <= '0;
         col_idx  <= '0;
         acc_hits <= '0;
         acc_code <= '0;
      end else if (slot_end) begin
         scan_cnt <= '0;
         col_idx  <= col_idx + 2'd1;
         if (frame_end) begin
            acc_hits <= '0;
            acc_code <= '0;
         end else begin
            acc_hits <= merged_hits;
            acc_code <= merged_code;
         end
      end else begin
         scan_cnt <= scan_cnt + SW'(1);
      end
   end

   // Debounce: the frame that first shows a key counts as frame 1.
   always_comb begin
      state_nxt   = state;
      deb_cnt_nxt = deb_cnt;
      cand_nxt    = cand;
      accept      = 1'b0;
      accept_code = cand;
      if (frame_end) begin
         case (state)
            KP_IDLE: begin
               if (frame_key) begin
                  state_nxt   = KP_PRESSING;
                  deb_cnt_nxt = FW'(1);
                  cand_nxt    = merged_code;
               end
            end
            KP_PRESSING: begin
               if (frame_key && (merged_code == cand)) begin
                  if (deb_cnt == DEB_LAST) begin
                     state_nxt   = KP_HELD;
                     deb_cnt_nxt = '0;
                     accept      = 1'b1;
                  end else begin
                     deb_cnt_nxt = deb_cnt + FW'(1);
                  end
               end else begin
                  state_nxt   = KP_IDLE;
                  deb_cnt_nxt = '0;
               end
            end
            KP_HELD: begin
               if (!frame_key) begin
                  state_nxt   = KP_RELEASING;
                  deb_cnt_nxt = FW'(1);
               end
            end
            KP_RELEASING: begin
               if (frame_key) begin
                  state_nxt   = KP_HELD;
                  deb_cnt_nxt = '0;
               end else if (deb_cnt == DEB_LAST) begin
                  state_nxt   = KP_IDLE;
                  deb_cnt_nxt = '0;
               end else begin
                  deb_cnt_nxt = deb_cnt + FW'(1);
               end
            end
            default: begin
               state_nxt   = KP_IDLE;
               deb_cnt_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clkin) begin
      if (rst) begin
         state     <= KP_IDLE;
         deb_cnt   <= '0;
         cand      <= '0;
         key_valid <= 1'b0;
         key_code  <= '0;
      end else begin
         state     <= state_nxt;
         deb_cnt   <= deb_cnt_nxt;
         cand      <= cand_nxt;
         key_valid <= accept;
         if (accept) begin
            key_code <= accept_code;
         end
      end
   end

endmodule

// File: rtl/keypad_time_source.sv
// keypad_time_source
//   Producer of the two-digit nums/numb 7-segment bus. In entry mode keys
//   shift digits in (value limited to 00..59, '*' clears); in run mode a
//   free-running 00..59 seconds count is shown instead.
//   Ports:
//     clkin, rst      clock, synchronous active-high reset
//     row_n[3:0]      keypad rows, active low
//     col_n[3:0]      keypad column drive, one bit low at a time
//     run             0 = entry mode, 1 = seconds-count mode
//     nums[6:0]       tens digit, 7-seg abcdefg
//     numb[6:0]       units digit, 7-seg abcdefg
//     key_valid       one-cycle pulse per accepted press
//     key_code[3:0]   last accepted key code
module keypad_time_source
   import medikit_pkg::*;
#(
   parameter int CLK_HZ      = 1000,
   parameter int SCAN_CYCLES = 250,
   parameter int DEBOUNCE    = 4
) (
   input  logic       clkin,
   input  logic       rst,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   input  logic       run,
   output logic [6:0] nums,
   output logic [6:0] numb,
   output logic       key_valid,
   output logic [3:0] key_code
);

   localparam int DW = $clog2(CLK_HZ);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_HZ - 1);

   logic          accept;
   logic [3:0]    accept_code;
   logic          run_q;
   logic          run_rise;
   logic          run_fall;
   logic [DW-1:0] div_cnt, div_nxt;
   logic [3:0]    tens, units, tens_nxt, units_nxt;
   logic [3:0]    key_digit;
   logic [6:0]    candidate;

   keypad_scan #(
      .SCAN_CYCLES (SCAN_CYCLES),
      .DEBOUNCE    (DEBOUNCE)
   ) u_scan (
      .clkin       (clkin),
      .rst         (rst),
      .row_n       (row_n),
      .col_n       (col_n),
      .accept      (accept),
      .accept_code (accept_code),
      .key_valid   (key_valid),
      .key_code    (key_code)
   );

   assign run_rise  = run & ~run_q;
   assign run_fall  = ~run & run_q;
   assign key_digit = key_to_digit(accept_code);
   assign candidate = 7'(units) * 7'd10 + 7'(key_digit);

   // Next digit values are computed here and both the BCD and the 7-seg
   // registers load from them, so a key shows on the bus in the same cycle
   // key_valid rises. Priority: run edge, then counting, then key entry.
   always_comb begin
      tens_nxt  = tens;
      units_nxt = units;
      div_nxt   = '0;
      if (run_rise || run_fall) begin
         tens_nxt  = '0;
         units_nxt = '0;
      end else if (run) begin
         if (div_cnt == DIV_LAST) begin
            if (units == 4'd9) begin
               units_nxt = '0;
               tens_nxt  = (tens == 4'd5) ? 4'd0 : tens + 4'd1;
            end else begin
               units_nxt = units + 4'd1;
            end
         end else begin
            div_nxt = div_cnt + DW'(1);
         end
      end else if (accept) begin
         if (accept_code == KEY_STAR) begin
            tens_nxt  = '0;
            units_nxt = '0;
         end else if (key_is_digit(accept_code) && (candidate <= 7'd59)) begin
            tens_nxt  = units;
            units_nxt = key_digit;
         end
      end
   end

   always_ff @(posedge clkin) begin
      if (rst) begin
         run_q   <= 1'b0;
         div_cnt <= '0;
         tens    <= '0;
         units   <= '0;
         nums    <= SEG_0;
         numb    <= SEG_0;
      end else begin
         run_q   <= run;
         div_cnt <= div_nxt;
         tens    <= tens_nxt;
         units   <= units_nxt;
         nums    <= bcd_to_seg(tens_nxt);
         numb    <= bcd_to_seg(units_nxt);
      end
   end

endmodule

// File: doc/keypad_time_source.md
# keypad_time_source

Producer side of the medicine-kit `nums`/`numb` digit bus. It scans a 4x4 active-low key matrix, debounces it, and assembles a two-digit entry value 00..59. When running, it instead generates a free-running 00..59 seconds count. Both digits are driven as 7-segment codes directly into the reminder controller's `nums`/`numb` inputs.

## Interface
- `CLK_HZ`, 1000: clkin cycles per second tick in run mode.
- `SCAN_CYCLES`, 250: clkin cycles each column stays driven.
- `DEBOUNCE`, 4: consecutive identical scan frames needed to accept a press or a release.
- `clkin` in 1: sole clock, all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `row_n` in 4: matrix rows, active low, externally pulled up.
- `col_n` out 4: matrix column drive, exactly one bit low at a time.
- `run` in 1: 0 = entry mode (keys edit digits); 1 = seconds-count mode.
- `nums` out 7: tens digit, 7-seg code.
- `numb` out 7: units digit, 7-seg code.
- `key_valid` out 1: one-cycle pulse per accepted press.
- `key_code` out 4: code of the last accepted key, held between pulses.

## Operation
- 7-seg codes are abcdefg, MSB = a:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- 0000000 is never driven, so the controller's cleared slots never match.
- Scan:
  - `col_n` rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing every `SCAN_CYCLES` cycles.
  - `row_n` is sampled on the last cycle of each column slot.
  - A frame is 4 slots. Frame result = key code r*4+c if exactly one (row, col) was low during the whole frame; otherwise "none". Multiple keys count as none.
- Key codes by row:
  - row0: 1,2,3,A → codes 0..3
  - row1: 4,5,6,B → codes 4..7
  - row2: 7,8,9,C → codes 8..11
  - row3: \*,0,#,D → codes 12..15
- Debounce FSM:
  - IDLE -> PRESSING when a key is seen.
  - PRESSING -> HELD after `DEBOUNCE` consecutive frames of the same key. On that transition, pulse `key_valid` and load `key_code`.
  - PRESSING -> IDLE if a frame differs.
  - HELD -> RELEASING on a none frame. RELEASING -> IDLE after `DEBOUNCE` consecutive none frames. RELEASING -> HELD on any key frame.
  - No auto-repeat. A new key while HELD is not accepted until release completes.
- Entry mode (`run`=0), on an accepted key:
  - Digit d: candidate = {units, d}. If candidate <= 59, then tens <= units and units <= d. Otherwise the key is discarded and the digits are unchanged.
  - `*`: digits <= 00.
  - Other keys: digits unchanged. `key_valid`/`key_code` are still reported.
- Run mode:
  - A rising edge of `run` (sampled) loads 00 and clears the divider.
  - The divider counts 0..`CLK_HZ`-1; at terminal count units increments.
  - Units 9 -> 0 with tens+1; 59 -> 00 wrap.
  - Keys are reported but never alter digits.
  - A falling edge of `run` loads 00.
- Widths: digits are held as 4-bit BCD internally. The divider is $clog2(`CLK_HZ`) bits. The scan counter is $clog2(`SCAN_CYCLES`) bits. The frame counter is $clog2(`DEBOUNCE`+1) bits.

## Timing
- Reset values:
  - `col_n`=1110
  - `nums`=`numb`=1111110 (00)
  - `key_valid`=0, `key_code`=0000
  - Debounce FSM IDLE, all counters 0, BCD digits 0
- Reset mid-scan or mid-count discards all progress. The first column slot after reset is a full `SCAN_CYCLES`.
- Press latency: `key_valid` rises on the cycle after the last sample of the `DEBOUNCE`-th matching frame. In entry mode, `nums`/`numb` show the new value on the same cycle as `key_valid` (same registered update).
- Run mode: the first increment becomes visible `CLK_HZ` cycles after the cycle `run` is first sampled high. Each later increment follows every `CLK_HZ` cycles.
- `run` edge and accepted key on the same cycle: the `run` edge wins and digits load 00.
- `rst` overrides everything.

## Structure
- Package `medikit_pkg`:
  - 7-seg digit constants SEG_0..SEG_9
  - key codes KEY_STAR=12, KEY_HASH=14
  - function `bcd_to_seg`
  - shared with the display and controller blocks
- Sub-module `keypad_scan` holds the column rotation, frame assembly and debounce FSM. It outputs the `key_valid`/`key_code` pulse.
- The top holds the digit register, entry logic, seconds divider and 7-seg output registers.

## Test plan
- Reset, no keys: `col_n` cycles 1110,1101,1011,0111 at 250-cycle steps; `nums`=`numb`=1111110; `key_valid` never pulses.
- Press key `4` (row1/col0) held 6 frames, `run`=0: exactly one `key_valid`, `key_code`=4; `numb`=0110011, `nums`=1111110. Releasing after 4 none frames gives no second pulse.
- Enter 5 then 9 -> `nums`=1011011, `numb`=1111011. A further `7` (candidate 97) is discarded, display stays 59. `*` -> 00.
- Bounce: key present 3 frames, none 1 frame, present 3 frames -> no `key_valid`. Two keys pressed simultaneously for 10 frames -> no `key_valid`.
- `CLK_HZ`=10, `run` 0->1: 00, then 01 after 10 cycles; 59 -> 00 after 600 cycles. A digit key during run changes nothing. `run` -> 0 gives 00.
- `rst` asserted mid-PRESSING and mid-count: next cycle all outputs at reset values. The pending press is not reported.
